// File: rtl/glb_loop_addr_gen.sv
// rtl/glb_loop_addr_gen.sv - multi-level loop address/schedule generator for a GLB DMA channel
// Optional stall counter output perf_stall_cnt is enabled by GLB_ADDR_GEN_PERF_CNT_EN.
module glb_loop_addr_gen #(
  parameter int LOOP_LEVEL  = 8,
  parameter int ADDR_WIDTH  = 19,
  parameter int RANGE_WIDTH = 17,
  parameter int CYCLE_WIDTH = 16,
  parameter int DIM_WIDTH   = $clog2(LOOP_LEVEL + 1)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              stall,
  input  logic [DIM_WIDTH-1:0]              cfg_dim,
  input  logic [ADDR_WIDTH-1:0]             cfg_start_addr,
  input  logic [LOOP_LEVEL*RANGE_WIDTH-1:0] cfg_range,
  input  logic [LOOP_LEVEL*ADDR_WIDTH-1:0]  cfg_stride,
  input  logic [CYCLE_WIDTH-1:0]            cfg_cycle_start,
  input  logic [LOOP_LEVEL*CYCLE_WIDTH-1:0] cfg_cycle_stride,
  output logic [ADDR_WIDTH-1:0]             addr_out,
  output logic                              addr_valid,
  output logic                              busy,
`ifdef GLB_ADDR_GEN_PERF_CNT_EN
  output logic [CYCLE_WIDTH-1:0]            perf_stall_cnt,
`endif
  output logic                              done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state_q, state_d;
  logic [DIM_WIDTH-1:0]   dim_q;
  logic [ADDR_WIDTH-1:0]  base_q;
  logic [ADDR_WIDTH-1:0]  hold_q;
  logic [CYCLE_WIDTH-1:0] cnt_q;
  logic [CYCLE_WIDTH-1:0] gap_q;
  logic                   done_q;
  logic [RANGE_WIDTH-1:0] last_q   [LOOP_LEVEL];
  logic [ADDR_WIDTH-1:0]  stride_q [LOOP_LEVEL];
  logic [CYCLE_WIDTH-1:0] cstride_q[LOOP_LEVEL];
  logic [RANGE_WIDTH-1:0] it_q     [LOOP_LEVEL];
  // Per-level running products it[i]*stride[i] and it[i]*cycle_stride[i]
  logic [ADDR_WIDTH-1:0]  aoff_q   [LOOP_LEVEL];
  logic [CYCLE_WIDTH-1:0] toff_q   [LOOP_LEVEL];

  logic                   fire;
  logic                   adv_any;
  logic [DIM_WIDTH-1:0]   adv_lvl;
  logic [ADDR_WIDTH-1:0]  cur_addr;
  logic [CYCLE_WIDTH-1:0] lower_t;
  logic [CYCLE_WIDTH-1:0] csel;
  logic [CYCLE_WIDTH-1:0] diff;
  logic [CYCLE_WIDTH-1:0] gap_nxt;

  always_comb begin
    adv_any  = 1'b0;
    adv_lvl  = '0;
    cur_addr = base_q;
    for (int i = 0; i < LOOP_LEVEL; i++) begin
      cur_addr = cur_addr + aoff_q[i];
      if (!adv_any && (DIM_WIDTH'(i) < dim_q) && (it_q[i] != last_q[i])) begin
        adv_any = 1'b1;
        adv_lvl = DIM_WIDTH'(i);
      end
    end
  end

  // Spacing to the next issue is target(next)-target(cur); a spacing of d cycles needs gap d-1
  always_comb begin
    lower_t = '0;
    csel    = '0;
    for (int i = 0; i < LOOP_LEVEL; i++) begin
      if (DIM_WIDTH'(i) < adv_lvl) lower_t = lower_t + toff_q[i];
      if (DIM_WIDTH'(i) == adv_lvl) csel = cstride_q[i];
    end
    diff    = csel - lower_t;
    gap_nxt = (diff[CYCLE_WIDTH-1] || diff == '0) ? '0 : diff - CYCLE_WIDTH'(1);
  end

  assign fire = (state_q == RUN) && !stall && (cnt_q == gap_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && cfg_dim != '0) state_d = RUN;
      RUN:     if (fire && !adv_any) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dim_q  <= '0;
      base_q <= '0;
      hold_q <= '0;
      cnt_q  <= '0;
      gap_q  <= '0;
      done_q <= 1'b0;
      for (int i = 0; i < LOOP_LEVEL; i++) begin
        last_q[i]    <= '0;
        stride_q[i]  <= '0;
        cstride_q[i] <= '0;
        it_q[i]      <= '0;
        aoff_q[i]    <= '0;
        toff_q[i]    <= '0;
      end
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (start) begin
          dim_q  <= cfg_dim;
          base_q <= cfg_start_addr;
          cnt_q  <= '0;
          gap_q  <= cfg_cycle_start;
          if (cfg_dim == '0) done_q <= 1'b1;
          for (int i = 0; i < LOOP_LEVEL; i++) begin
            last_q[i]    <= (cfg_range[i*RANGE_WIDTH +: RANGE_WIDTH] == '0) ? '0 :
                            cfg_range[i*RANGE_WIDTH +: RANGE_WIDTH] - RANGE_WIDTH'(1);
            stride_q[i]  <= cfg_stride[i*ADDR_WIDTH +: ADDR_WIDTH];
            cstride_q[i] <= cfg_cycle_stride[i*CYCLE_WIDTH +: CYCLE_WIDTH];
            it_q[i]      <= '0;
            aoff_q[i]    <= '0;
            toff_q[i]    <= '0;
          end
        end
      end else if (!stall) begin
        if (cnt_q == gap_q) begin
          hold_q <= cur_addr;
          cnt_q  <= '0;
          if (adv_any) begin
            gap_q <= gap_nxt;
            for (int i = 0; i < LOOP_LEVEL; i++) begin
              if (DIM_WIDTH'(i) == adv_lvl) begin
                it_q[i]   <= it_q[i] + RANGE_WIDTH'(1);
                aoff_q[i] <= aoff_q[i] + stride_q[i];
                toff_q[i] <= toff_q[i] + cstride_q[i];
              end else if (DIM_WIDTH'(i) < adv_lvl) begin
                it_q[i]   <= '0;
                aoff_q[i] <= '0;
                toff_q[i] <= '0;
              end
            end
          end else begin
            done_q <= 1'b1;
          end
        end else begin
          cnt_q <= cnt_q + CYCLE_WIDTH'(1);
        end
      end
    end
  end

`ifdef GLB_ADDR_GEN_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      perf_stall_cnt <= '0;
    else if (state_q == IDLE && start)
      perf_stall_cnt <= '0;
    else if (state_q == RUN && stall && perf_stall_cnt != '1)
      perf_stall_cnt <= perf_stall_cnt + CYCLE_WIDTH'(1);
  end
`endif

  assign addr_valid = fire;
  assign addr_out   = fire ? cur_addr : hold_q;
  assign busy       = (state_q == RUN);
  assign done       = done_q;

endmodule

// File: tb/tb_glb_loop_addr_gen.sv
// tb/tb_glb_loop_addr_gen.sv - self-checking bench for glb_loop_addr_gen
module tb_glb_loop_addr_gen;
  localparam int LL = 8;
  localparam int AW = 19;
  localparam int RW = 17;
  localparam int CW = 16;
  localparam int DW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic stall = 1'b0;
  logic [DW-1:0] cfg_dim = '0;
  logic [AW-1:0] cfg_start_addr = '0;
  logic [CW-1:0] cfg_cycle_start = '0;
  logic [RW-1:0] rng[LL];
  logic [AW-1:0] str[LL];
  logic [CW-1:0] cst[LL];
  logic [LL*RW-1:0] cfg_range;
  logic [LL*AW-1:0] cfg_stride;
  logic [LL*CW-1:0] cfg_cycle_stride;
  logic [AW-1:0] addr_out;
  logic addr_valid, busy, done;
`ifdef GLB_ADDR_GEN_PERF_CNT_EN
  logic [CW-1:0] perf_stall_cnt;
`endif

  always_comb begin
    cfg_range = '0;
    cfg_stride = '0;
    cfg_cycle_stride = '0;
    for (int i = 0; i < LL; i++) begin
      cfg_range[i*RW +: RW] = rng[i];
      cfg_stride[i*AW +: AW] = str[i];
      cfg_cycle_stride[i*CW +: CW] = cst[i];
    end
  end

  glb_loop_addr_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .cfg_dim(cfg_dim), .cfg_start_addr(cfg_start_addr), .cfg_range(cfg_range),
    .cfg_stride(cfg_stride), .cfg_cycle_start(cfg_cycle_start),
    .cfg_cycle_stride(cfg_cycle_stride), .addr_out(addr_out),
    .addr_valid(addr_valid), .busy(busy),
`ifdef GLB_ADDR_GEN_PERF_CNT_EN
    .perf_stall_cnt(perf_stall_cnt),
`endif
    .done(done));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t0 = 0;
  int log_t[$];
  logic [AW-1:0] log_a[$];
  int done_t[$];

  // Reference model: the full issue list is enumerated up front, then replayed against the schedule
  logic [AW-1:0] q_a[$];
  logic [CW-1:0] q_t[$];
  bit m_busy = 0, m_done = 0;
  int m_k = 0, m_el = 0, m_need = 0, m_n = 0;
  logic [AW-1:0] m_last = '0;
  logic [CW-1:0] m_perf = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int eff(input int i);
    return (rng[i] == 0) ? 1 : int'(rng[i]);
  endfunction

  task automatic build();
    int rem, it;
    logic [AW-1:0] a;
    logic [CW-1:0] t;
    q_a.delete();
    q_t.delete();
    m_n = 1;
    for (int i = 0; i < int'(cfg_dim); i++) m_n *= eff(i);
    for (int k = 0; k < m_n; k++) begin
      rem = k;
      a = cfg_start_addr;
      t = cfg_cycle_start;
      for (int i = 0; i < int'(cfg_dim); i++) begin
        it = rem % eff(i);
        rem = rem / eff(i);
        a = a + AW'(it) * str[i];
        t = t + CW'(it) * cst[i];
      end
      q_a.push_back(a);
      q_t.push_back(t);
    end
  endtask

  initial forever @(posedge clk) cyc++;

  initial begin : cmp
    logic ev, dn;
    logic [AW-1:0] ea;
    logic signed [CW-1:0] dd;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_addr", addr_out, 0);
        chk("rst_valid", addr_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
`ifdef GLB_ADDR_GEN_PERF_CNT_EN
        chk("rst_perf", perf_stall_cnt, 0);
`endif
        m_busy = 0; m_done = 0; m_last = '0; m_perf = '0;
      end else begin
        ev = m_busy && !stall && (m_el == m_need);
        ea = ev ? q_a[m_k] : m_last;
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("addr_valid", addr_valid, ev);
        chk("addr_out", addr_out, ea);
`ifdef GLB_ADDR_GEN_PERF_CNT_EN
        chk("perf", perf_stall_cnt, m_perf);
`endif
        if (addr_valid) begin
          log_t.push_back(cyc - t0);
          log_a.push_back(addr_out);
        end
        if (done) done_t.push_back(cyc - t0);
        dn = 0;
        if (m_busy) begin
          if (stall) begin
            if (m_perf != '1) m_perf++;
          end else if (ev) begin
            m_last = ea;
            m_k++;
            m_el = 0;
            if (m_k == m_n) begin
              m_busy = 0;
              dn = 1;
            end else begin
              dd = $signed(q_t[m_k] - q_t[m_k-1]);
              m_need = (dd < 1) ? 0 : int'(dd) - 1;
            end
          end else begin
            m_el++;
          end
        end else if (start) begin
          m_perf = '0;
          build();
          if (cfg_dim == 0) dn = 1;
          else begin
            m_busy = 1; m_k = 0; m_el = 0; m_need = int'(cfg_cycle_start);
          end
        end
        m_done = dn;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic launch();
    start = 1'b1;
    t0 = cyc;
    tick(1);
    start = 1'b0;
  endtask

  task automatic clear_cfg();
    for (int i = 0; i < LL; i++) begin
      rng[i] = '0; str[i] = '0; cst[i] = '0;
    end
    log_t.delete(); log_a.delete(); done_t.delete();
  endtask

  task automatic set_1d();
    clear_cfg();
    cfg_dim = 1; cfg_start_addr = 'h100; cfg_cycle_start = 2;
    rng[0] = 4; str[0] = 8; cst[0] = 1;
  endtask

  task automatic check_seq(input string nm, input int n, input int et[8],
                           input logic [AW-1:0] ea[8], input int dr);
    chk({nm, "_count"}, log_t.size(), n);
    for (int i = 0; i < n && i < log_t.size(); i++) begin
      chk({nm, "_cycle"}, log_t[i], et[i]);
      chk({nm, "_addr"}, log_a[i], ea[i]);
    end
    chk({nm, "_done_count"}, done_t.size(), 1);
    if (done_t.size() > 0) chk({nm, "_done_cycle"}, done_t[0], dr);
    chk({nm, "_idle"}, busy, 0);
  endtask

  initial begin
    int et[8];
    logic [AW-1:0] ea[8];
    clear_cfg();
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // 1-D sweep
    set_1d();
    launch();
    tick(20);
    et = '{3, 4, 5, 6, 0, 0, 0, 0};
    ea = '{'h100, 'h108, 'h110, 'h118, 0, 0, 0, 0};
    check_seq("one_d", 4, et, ea, 7);

    // 2-D with differing cycle strides
    clear_cfg();
    cfg_dim = 2; cfg_start_addr = 0; cfg_cycle_start = 0;
    rng[0] = 2; rng[1] = 3; str[0] = 1; str[1] = 'h40; cst[0] = 2; cst[1] = 5;
    launch();
    tick(25);
    et = '{1, 3, 6, 8, 11, 13, 0, 0};
    ea = '{'h00, 'h01, 'h40, 'h41, 'h80, 'h81, 0, 0};
    check_seq("two_d", 6, et, ea, 14);

    // Negative stride with a two-cycle stall
    clear_cfg();
    cfg_dim = 1; cfg_start_addr = 0; cfg_cycle_start = 0;
    rng[0] = 3; str[0] = 'h7FFFF; cst[0] = 0;
    launch();
    tick(1);
    stall = 1'b1;
    tick(2);
    stall = 1'b0;
    tick(15);
    et = '{1, 4, 5, 0, 0, 0, 0, 0};
    ea = '{'h0, 'h7FFFF, 'h7FFFE, 0, 0, 0, 0, 0};
    check_seq("stall_neg", 3, et, ea, 6);
`ifdef GLB_ADDR_GEN_PERF_CNT_EN
    chk("perf_literal", perf_stall_cnt, 2);
`endif

    // dim=0 completes at once with no issue
    clear_cfg();
    cfg_dim = 0;
    launch();
    tick(10);
    check_seq("dim_zero", 0, et, ea, 1);

    // 3-D with a zero range and a negative schedule step
    clear_cfg();
    cfg_dim = 3; cfg_start_addr = 'h40; cfg_cycle_start = 1;
    rng[0] = 2; rng[1] = 0; rng[2] = 2;
    str[0] = 4; str[1] = 'h100; str[2] = 'h10;
    cst[0] = 3; cst[1] = 7; cst[2] = 0;
    launch();
    tick(20);
    et = '{2, 5, 6, 9, 0, 0, 0, 0};
    ea = '{'h40, 'h44, 'h50, 'h54, 0, 0, 0, 0};
    check_seq("three_d", 4, et, ea, 10);

    // start during RUN is ignored
    set_1d();
    launch();
    tick(3);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(20);
    et = '{3, 4, 5, 6, 0, 0, 0, 0};
    ea = '{'h100, 'h108, 'h110, 'h118, 0, 0, 0, 0};
    check_seq("start_in_run", 4, et, ea, 7);

    // Reset mid-RUN aborts asynchronously with no done
    set_1d();
    launch();
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_addr", addr_out, 0);
    chk("async_valid", addr_valid, 0);
    chk("async_busy", busy, 0);
    chk("async_done", done, 0);
    tick(2);
    rst_n = 1'b1;
    tick(10);
    chk("abort_issues", log_t.size(), 1);
    chk("abort_no_done", done_t.size(), 0);
    set_1d();
    launch();
    tick(20);
    check_seq("replay", 4, et, ea, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
